// File: rtl/prog_loader.sv
// prog_loader: boot loader that streams a program into instruction memory, releases the CPU and watchdogs its run
module prog_loader #(
    parameter logic [15:0] TIMEOUT = 16'd10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        cpu_done,
    output logic        im_we,
    output logic [7:0]  im_addr,
    output logic [8:0]  im_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        run_done,
    output logic [15:0] run_cycles,
    output logic        err,
    output logic [1:0]  err_code
);
    typedef enum logic [2:0] {
        S_INIT, S_LEN, S_LO, S_HI, S_SETTLE, S_RUN, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  lo_q, lo_d;
    logic        im_we_q, im_we_d;
    logic [7:0]  im_addr_q, im_addr_d;
    logic [8:0]  im_wdata_q, im_wdata_d;
    logic [15:0] run_cycles_q, run_cycles_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        xfer;

    assign in_ready   = (state_q == S_LEN) || (state_q == S_LO) || (state_q == S_HI);
    assign load_done  = (state_q == S_RUN) || (state_q == S_DONE);
    assign cpu_reset  = !load_done;
    assign run_done   = state_q == S_DONE;
    assign err        = state_q == S_ERR;
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign run_cycles = run_cycles_q;
    assign err_code   = err_code_q;
    assign xfer       = in_valid && in_ready;

    // Next-state: byte parsing, memory write issue, run timing and watchdog
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        addr_d       = addr_q;
        lo_d         = lo_q;
        im_we_d      = 1'b0;
        im_addr_d    = im_addr_q;
        im_wdata_d   = im_wdata_q;
        run_cycles_d = run_cycles_q;
        err_code_d   = err_code_q;
        case (state_q)
            S_INIT: state_d = S_LEN;
            S_LEN: if (xfer) begin
                rem_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                addr_d  = 8'd0;
                state_d = S_LO;
            end
            S_LO: if (xfer) begin
                lo_d    = in_data;
                state_d = S_HI;
            end
            S_HI: if (xfer) begin
                if (|in_data[7:1]) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd1;
                end else begin
                    im_we_d    = 1'b1;
                    im_addr_d  = addr_q;
                    im_wdata_d = {in_data[0], lo_q};
                    addr_d     = addr_q + 8'd1;
                    rem_d      = rem_q - 9'd1;
                    state_d    = (rem_q == 9'd1) ? S_SETTLE : S_LO;
                end
            end
            S_SETTLE: state_d = S_RUN;
            S_RUN: if (cpu_done) begin
                state_d = S_DONE;
            end else begin
                run_cycles_d = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;
                if ((TIMEOUT != 16'd0) && (run_cycles_q == TIMEOUT - 16'd1)) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd2;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            rem_q        <= 9'd0;
            addr_q       <= 8'd0;
            lo_q         <= 8'd0;
            im_we_q      <= 1'b0;
            im_addr_q    <= 8'd0;
            im_wdata_q   <= 9'd0;
            run_cycles_q <= 16'd0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            addr_q       <= addr_d;
            lo_q         <= lo_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            run_cycles_q <= run_cycles_d;
            err_code_q   <= err_code_d;
        end
    end
endmodule
